// File: rtl/score_pkg.sv
// Shared types and the active-low 7-segment encoding for the score display.
package score_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Index is the decimal digit; bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [6:0] bcd_to_seg(input bcd_t d);
    if (d <= 4'd9) return SEG_TABLE[d];
    return SEG_BLANK;
  endfunction

endpackage

// File: rtl/score_display_counter_if.sv
// Strobe inputs from game control and display/status outputs of the score counter.
interface score_display_counter_if #(
  parameter int unsigned N_DIGITS  = 2,
  parameter int unsigned MAX_COUNT = 99
);
  localparam int unsigned CW = $clog2(MAX_COUNT + 1);

  logic                    inc;
  logic                    dec;
  logic                    clr;
  logic [CW-1:0]           count;
  logic [7*N_DIGITS-1:0]   seg;
  logic                    at_max;
  logic                    at_zero;

  modport master (output inc, dec, clr, input count, seg, at_max, at_zero);
  modport slave  (input inc, dec, clr, output count, seg, at_max, at_zero);

endinterface

// File: rtl/score_display_counter_bcd_digit.sv
// One BCD digit of the score: steps up/down with carry/borrow, or loads a constant.
module bcd_digit
  import score_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic step_up_i,
  input  logic step_dn_i,
  input  logic load_i,
  input  bcd_t load_val_i,
  output bcd_t digit_o,
  output logic carry_o,
  output logic borrow_o
);

  bcd_t digit_q, digit_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) digit_q <= '0;
    else         digit_q <= digit_d;
  end

  always_comb begin
    digit_d = digit_q;
    if (load_i)         digit_d = load_val_i;
    else if (step_up_i) digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    else if (step_dn_i) digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
  end

  assign digit_o  = digit_q;
  assign carry_o  = step_up_i && (digit_q == 4'd9);
  assign borrow_o = step_dn_i && (digit_q == 4'd0);

endmodule

// File: rtl/score_display_counter.sv
// Up/down decimal score counter with BCD digits, 7-seg drive, blanking and max blink.
module score_display_counter
  import score_pkg::*;
#(
  parameter int unsigned N_DIGITS  = 2,
  parameter int unsigned MAX_COUNT = 99,
  parameter int unsigned WRAP      = 0,
  parameter int unsigned LZ_BLANK  = 1,
  parameter int unsigned BLINK_DIV = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  score_display_counter_if.slave  bus
);

  localparam int unsigned CW = $clog2(MAX_COUNT + 1);
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam bit BLINK_EN = (WRAP == 0) && (BLINK_DIV > 0);

  // Elaboration-time BCD image of MAX_COUNT, used for the wrap-on-dec load.
  function automatic bcd_t max_digit(input int unsigned k);
    int unsigned v;
    v = MAX_COUNT;
    for (int unsigned i = 0; i < k; i++) v = v / 10;
    return bcd_t'(v % 10);
  endfunction

  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          hidden_q, hidden_d;

  logic at_max, at_zero;
  logic step_up0, step_dn0, load, load_max;

  bcd_t                digit  [N_DIGITS];
  logic [N_DIGITS-1:0] carry, borrow, digit_nz, show;
  logic [7*N_DIGITS-1:0] seg_w;

  assign at_max  = (count_q == CW'(MAX_COUNT));
  assign at_zero = (count_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q     <= '0;
      blink_cnt_q <= '0;
      hidden_q    <= 1'b0;
    end else begin
      count_q     <= count_d;
      blink_cnt_q <= blink_cnt_d;
      hidden_q    <= hidden_d;
    end
  end

  always_comb begin
    count_d  = count_q;
    step_up0 = 1'b0;
    step_dn0 = 1'b0;
    load     = 1'b0;
    load_max = 1'b0;
    if (bus.clr) begin
      count_d = '0;
      load    = 1'b1;
    end else if (bus.inc ^ bus.dec) begin
      if (bus.inc) begin
        if (!at_max) begin
          count_d  = count_q + CW'(1);
          step_up0 = 1'b1;
        end else if (WRAP != 0) begin
          count_d = '0;
          load    = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count_d  = count_q - CW'(1);
          step_dn0 = 1'b1;
        end else if (WRAP != 0) begin
          count_d  = CW'(MAX_COUNT);
          load     = 1'b1;
          load_max = 1'b1;
        end
      end
    end
  end

  // Blink only advances while staying at max, so leaving max resets it on the same edge.
  always_comb begin
    blink_cnt_d = '0;
    hidden_d    = 1'b0;
    if (BLINK_EN && at_max && (count_d == CW'(MAX_COUNT))) begin
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        hidden_d    = ~hidden_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        hidden_d    = hidden_q;
      end
    end
  end

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    localparam bcd_t IMG = max_digit(k);

    bcd_digit u_digit (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .step_up_i  ((k == 0) ? step_up0 : carry[(k == 0) ? 0 : k-1]),
      .step_dn_i  ((k == 0) ? step_dn0 : borrow[(k == 0) ? 0 : k-1]),
      .load_i     (load),
      .load_val_i (load_max ? IMG : bcd_t'(0)),
      .digit_o    (digit[k]),
      .carry_o    (carry[k]),
      .borrow_o   (borrow[k])
    );

    assign digit_nz[k] = (digit[k] != '0);
    assign show[k]     = (k == 0) || (LZ_BLANK == 0) || (|digit_nz[N_DIGITS-1:k]);
    assign seg_w[7*k +: 7] = (hidden_q || !show[k]) ? SEG_BLANK : bcd_to_seg(digit[k]);
  end

  // The top digit never carries or borrows because count stays within 0..MAX_COUNT.
  logic unused_top;
  assign unused_top = &{1'b0, carry[N_DIGITS-1], borrow[N_DIGITS-1]};

  assign bus.count   = count_q;
  assign bus.seg     = seg_w;
  assign bus.at_max  = at_max;
  assign bus.at_zero = at_zero;

endmodule

// File: tb/tb_score_display_counter.sv
// Randomised + directed bench for score_display_counter across three parameter sets.
module tb_score_display_counter;

  localparam int unsigned NI = 3;
  localparam int unsigned NDP  [NI] = '{2, 2, 3};
  localparam int unsigned MAXC [NI] = '{99, 59, 250};
  localparam int unsigned WRP  [NI] = '{0, 1, 0};
  localparam int unsigned LZP  [NI] = '{1, 1, 0};
  localparam int unsigned DIVP [NI] = '{4, 0, 3};

  localparam logic [6:0] TBL [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  score_display_counter_if #(.N_DIGITS(2), .MAX_COUNT(99))  ifa ();
  score_display_counter_if #(.N_DIGITS(2), .MAX_COUNT(59))  ifb ();
  score_display_counter_if #(.N_DIGITS(3), .MAX_COUNT(250)) ifc ();

  score_display_counter #(.N_DIGITS(2), .MAX_COUNT(99), .WRAP(0), .LZ_BLANK(1), .BLINK_DIV(4))
    dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(ifa));
  score_display_counter #(.N_DIGITS(2), .MAX_COUNT(59), .WRAP(1), .LZ_BLANK(1), .BLINK_DIV(0))
    dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(ifb));
  score_display_counter #(.N_DIGITS(3), .MAX_COUNT(250), .WRAP(0), .LZ_BLANK(0), .BLINK_DIV(3))
    dut_c (.clk_i(clk), .rst_ni(rst_n), .bus(ifc));

  int checks = 0;
  int errors = 0;

  // Reference state: score value and number of edges spent continuously at max.
  int m_cnt [NI];
  int m_run [NI];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_seg(input int c, input int unsigned j);
    logic [63:0] s;
    int p;
    bit hid;
    s = '0;
    p = 1;
    hid = (WRP[j] == 0) && (DIVP[j] > 0) && (c == int'(MAXC[j])) &&
          (((m_run[j] / int'(DIVP[j])) % 2) == 1);
    for (int unsigned k = 0; k < NDP[j]; k++) begin
      bit blank;
      blank = hid || ((LZP[j] != 0) && (k > 0) && (c / p == 0));
      s |= 64'(blank ? 7'h7f : TBL[(c / p) % 10]) << (7 * k);
      p *= 10;
    end
    return s;
  endfunction

  task automatic model_reset();
    for (int unsigned j = 0; j < NI; j++) begin
      m_cnt[j] = 0;
      m_run[j] = 0;
    end
  endtask

  task automatic model_step(input bit i, input bit d, input bit c);
    for (int unsigned j = 0; j < NI; j++) begin
      int nx;
      int mx;
      mx = int'(MAXC[j]);
      nx = m_cnt[j];
      if (c) nx = 0;
      else if (i && !d) nx = (m_cnt[j] < mx) ? m_cnt[j] + 1 : ((WRP[j] != 0) ? 0 : m_cnt[j]);
      else if (d && !i) nx = (m_cnt[j] > 0) ? m_cnt[j] - 1 : ((WRP[j] != 0) ? mx : m_cnt[j]);
      m_run[j] = (m_cnt[j] == mx && nx == mx) ? m_run[j] + 1 : 0;
      m_cnt[j] = nx;
    end
  endtask

  task automatic compare_all(input string ph);
    logic [63:0] o_cnt [NI];
    logic [63:0] o_seg [NI];
    logic        o_max [NI];
    logic        o_zer [NI];
    o_cnt[0] = 64'(ifa.count); o_seg[0] = 64'(ifa.seg); o_max[0] = ifa.at_max; o_zer[0] = ifa.at_zero;
    o_cnt[1] = 64'(ifb.count); o_seg[1] = 64'(ifb.seg); o_max[1] = ifb.at_max; o_zer[1] = ifb.at_zero;
    o_cnt[2] = 64'(ifc.count); o_seg[2] = 64'(ifc.seg); o_max[2] = ifc.at_max; o_zer[2] = ifc.at_zero;
    for (int unsigned j = 0; j < NI; j++) begin
      string t;
      t = $sformatf("%s[%0d]", ph, j);
      check({t, ".count"},   o_cnt[j], 64'(m_cnt[j]));
      check({t, ".seg"},     o_seg[j], exp_seg(m_cnt[j], j));
      check({t, ".at_max"},  64'(o_max[j]), 64'(m_cnt[j] == int'(MAXC[j])));
      check({t, ".at_zero"}, 64'(o_zer[j]), 64'(m_cnt[j] == 0));
    end
  endtask

  task automatic drive(input bit i, input bit d, input bit c);
    ifa.inc = i; ifa.dec = d; ifa.clr = c;
    ifb.inc = i; ifb.dec = d; ifb.clr = c;
    ifc.inc = i; ifc.dec = d; ifc.clr = c;
  endtask

  task automatic cycle(input string ph, input bit i, input bit d, input bit c);
    drive(i, d, c);
    @(posedge clk);
    model_step(i, d, c);
    @(negedge clk);
    compare_all(ph);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    rst_n = 1'b1;
    cycle("idle", 0, 0, 0);

    repeat (10) cycle("inc10", 1, 0, 0);
    check("inc10.seg_a_literal", 64'(ifa.seg), 64'(14'b1111001_1000000));
    cycle("dec1", 0, 1, 0);

    repeat (120) cycle("sat", 1, 0, 0);
    repeat (2) cycle("satdec", 0, 1, 0);

    cycle("clr", 0, 0, 1);
    cycle("wrapdec", 0, 1, 0);
    check("wrapdec.seg_b_literal", 64'(ifb.seg), 64'(14'b0010010_0010000));
    cycle("wrapinc", 1, 0, 0);

    cycle("clr2", 0, 0, 1);
    repeat (5) cycle("to5", 1, 0, 0);
    repeat (3) cycle("incdec", 1, 1, 0);
    cycle("allthree", 1, 1, 1);

    repeat (37) cycle("to37", 1, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_all("async_rst");
    drive(1'b1, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    cycle("post_rst", 1, 0, 0);

    for (int ph = 0; ph < 24; ph++) begin
      int unsigned pinc, pdec;
      pinc = $urandom_range(10, 95);
      pdec = $urandom_range(5, 60);
      for (int n = 0; n < 100; n++) begin
        bit ri, rd, rc;
        ri = ($urandom_range(0, 99) < pinc);
        rd = ($urandom_range(0, 99) < pdec);
        rc = ($urandom_range(0, 99) < 2);
        cycle("rand", ri, rd, rc);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_display_counter.md
Name: score_display_counter

Overview:
- Parametrised successor to the single-digit 0–7 victory counter.
- Holds an up/down decimal score across N_DIGITS BCD digits and drives one active-low 7-segment field per digit.
- Supports saturate or wrap at MAX_COUNT, optional leading-zero blanking, and optional blink while saturated at MAX_COUNT.
- Sits between game-control logic (inc/dec/clr strobes) and the board HEX displays.

Parameters:
- N_DIGITS, 2: number of BCD digits / 7-seg fields (1..6).
- MAX_COUNT, 99: terminal count. Must satisfy 0 < MAX_COUNT < 10**N_DIGITS.
- WRAP, 0: 0 = saturate at 0 / MAX_COUNT; 1 = wrap MAX_COUNT→0 on inc and 0→MAX_COUNT on dec.
- LZ_BLANK, 1: 1 = blank leading-zero digits. Digit 0 is always shown.
- BLINK_DIV, 0: cycles per blink half-period while saturated at max. 0 = blink disabled. Ignored when WRAP=1.
- CW, localparam = $clog2(MAX_COUNT+1): width of the binary count.

Ports:
- Clock  in  1  system clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset.
- inc  in  1  increment request, sampled every cycle.
- dec  in  1  decrement request, sampled every cycle.
- clr  in  1  synchronous clear to 0.
- count  out  CW  registered binary score.
- seg  out  7*N_DIGITS  active-low segments. seg[7k+6:7k] = digit k (k=0 is LSD), bit order {g,f,e,d,c,b,a}.
- at_max  out  1  count == MAX_COUNT.
- at_zero  out  1  count == 0.

Behaviour:
- Reset asserted (Reset=0), asynchronously:
  - count=0; all BCD digits=0; blink counter=0; blink phase=visible.
  - seg: digit 0 = 7'b1000000; other digits = 7'b1111111 if LZ_BLANK, else 7'b1000000.
  - at_zero=1, at_max=0.
- Priority each cycle: clr > (inc XOR dec) > hold.
  - inc=dec=1: hold, no change.
- One step per cycle while a request is held (level-sampled, no edge detect). Update visible on outputs the cycle after the sampling edge (1-cycle latency).
- inc, count<MAX_COUNT: count+1; BCD digits increment with ripple carry (9→0 carries into next digit).
- dec, count>0: count−1; BCD digits decrement with borrow (0→9 borrows from next digit).
- inc at MAX_COUNT: WRAP=1 → count and all digits to 0; WRAP=0 → hold.
- dec at 0: WRAP=1 → load MAX_COUNT and its BCD image (constant); WRAP=0 → hold.
- Binary count and BCD digits are always consistent. No runtime division or modulo.
- at_max, at_zero: combinational from registered count.
- Segment map (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Leading-zero blanking: digit k>0 blanks iff it and all higher digits are 0.
- Blink (WRAP=0, BLINK_DIV>0, at_max=1):
  - Counter counts 0..BLINK_DIV−1; phase toggles on terminal value.
  - Hidden phase forces all fields to blank.
  - Leaving max (dec or clr) zeroes counter and forces visible phase the same edge.
- Reset mid-operation overrides everything asynchronously. Release is synchronous to the next edge.

Decomposition:
- Package score_pkg:
  - SEG_BLANK and the 10-entry digit→segment constant table.
  - function bcd_to_seg.
  - typedef bcd_t (logic [3:0]).
- Sub-module bcd_digit:
  - inputs: step_up, step_dn, load, load_val.
  - outputs: digit, carry_out (9 & up), borrow_out (0 & dn).
  - N_DIGITS instances chained.
- Top holds: binary count, blink logic, blanking, priority logic.

Test Plan:
- Reset defaults (N_DIGITS=2): release reset, idle → count=0, seg=14'b1111111_1000000, at_zero=1, at_max=0.
- Carry/blanking: 10 inc cycles from 0 → count=10, seg digit1=1111001, digit0=1000000. dec 1 → count=9, digit1 blank.
- Saturate + blink (MAX_COUNT=99, WRAP=0, BLINK_DIV=4): hold inc 120 cycles → count=99, at_max=1, seg alternates 0010000_0010000 / all-1s every 4 cycles. One dec → count=98, steady display.
- Wrap (MAX_COUNT=59, WRAP=1): from 59 inc → 0. dec at 0 → 59, seg=0010010_0010000.
- Simultaneous/priority: count=5; inc=dec=1 → stays 5. inc=dec=clr=1 → 0 next edge.
- Async reset mid-count: assert Reset=0 between edges at count=37 → outputs return to reset values before the next Clock edge. inc held through release → count=1 after first active edge.
